// File: rtl/intr_ctrl_if.sv
// Exception/interrupt controller bundle between the core and intr_ctrl.
// master: core side (drives flags, irq lines, PCs); slave: intr_ctrl.
interface intr_ctrl_if;
    logic        exc_valid;
    logic        ovf;
    logic        divz;
    logic        ri;
    logic        brk;
    logic        sys;
    logic        eret;
    logic [5:0]  ext_irq;
    logic [5:0]  irq_mask;
    logic        global_ie;
    logic [31:0] exc_pc;
    logic [31:0] epc_in;
    logic        stall;
    logic        flush;
    logic        cp0_we;
    logic [4:0]  cause_code;
    logic [31:0] epc_out;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        in_handler;
    logic [5:0]  pending;

    modport master (
        output exc_valid, ovf, divz, ri, brk, sys, eret,
        output ext_irq, irq_mask, global_ie, exc_pc, epc_in,
        input  stall, flush, cp0_we, cause_code, epc_out,
        input  pc_redirect, redirect_pc, in_handler, pending
    );

    modport slave (
        input  exc_valid, ovf, divz, ri, brk, sys, eret,
        input  ext_irq, irq_mask, global_ie, exc_pc, epc_in,
        output stall, flush, cp0_we, cause_code, epc_out,
        output pc_redirect, redirect_pc, in_handler, pending
    );
endinterface

// File: rtl/intr_ctrl.sv
// Exception/interrupt sequencer: accept -> FLUSH -> SAVE -> REDIR, and ERET.
// Ports: clk, reset (sync, active-high), bus (intr_ctrl_if.slave).
// Option: define INTR_VECTORED_EN for per-line interrupt entry vectors.
module intr_ctrl (
    input  logic       clk,
    input  logic       reset,
    intr_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] FLUSH      = 3'd1;
    localparam logic [2:0] SAVE       = 3'd2;
    localparam logic [2:0] REDIR      = 3'd3;
    localparam logic [2:0] ERET_FLUSH = 3'd4;
    localparam logic [2:0] ERET_REDIR = 3'd5;

    localparam logic [31:0] ENTRY_BASE = 32'h0000_F500;

    logic [2:0]  state_q, state_d;
    logic [5:0]  pend_q, irq_prev_q;
    logic        in_handler_q;
    logic [4:0]  cause_q;
    logic [31:0] epc_q;

    logic [5:0]  irq_rise, eligible, clr_mask;
    logic        exc_any, idle;
    logic        take_exc, take_eret, take_irq;
    logic        irq_found;
    logic [2:0]  irq_line;
    logic [4:0]  exc_code;
    logic [31:0] entry_pc;

    assign irq_rise = bus.ext_irq & ~irq_prev_q;
    assign eligible = pend_q & bus.irq_mask;
    assign idle     = (state_q == IDLE);
    assign exc_any  = bus.sys | bus.divz | bus.brk | bus.ri | bus.ovf;

    // Lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        irq_found = 1'b0;
        irq_line  = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (eligible[i]) begin
                irq_found = 1'b1;
                irq_line  = 3'(i);
            end
        end
    end

    always_comb begin
        if (bus.sys)       exc_code = 5'b01000;
        else if (bus.divz) exc_code = 5'b00111;
        else if (bus.brk)  exc_code = 5'b01001;
        else if (bus.ri)   exc_code = 5'b01010;
        else               exc_code = 5'b01100;
    end

    assign take_exc  = idle & bus.exc_valid & exc_any;
    assign take_eret = idle & bus.exc_valid & bus.eret & ~exc_any;
    assign take_irq  = idle & ~take_exc & ~take_eret & irq_found
                     & bus.global_ie & ~in_handler_q;

    assign clr_mask = take_irq ? (6'b000001 << irq_line) : 6'b000000;

    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE: begin
                if (take_exc | take_irq) state_d = FLUSH;
                else if (take_eret)      state_d = ERET_FLUSH;
                else                     state_d = IDLE;
            end
            FLUSH:      state_d = SAVE;
            SAVE:       state_d = REDIR;
            REDIR:      state_d = IDLE;
            ERET_FLUSH: state_d = ERET_REDIR;
            ERET_REDIR: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // A new edge is OR-ed in after the clear, so set wins on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= 6'd0;
            irq_prev_q   <= 6'd0;
            in_handler_q <= 1'b0;
            cause_q      <= 5'd0;
            epc_q        <= 32'd0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= bus.ext_irq;
            pend_q     <= (pend_q & ~clr_mask) | irq_rise;
            if (take_exc | take_irq) begin
                cause_q <= take_exc ? exc_code : 5'd0;
                epc_q   <= bus.exc_pc;
            end
            // Handler flag changes as the redirect cycle begins.
            if (state_q == SAVE)
                in_handler_q <= 1'b1;
            else if (state_q == ERET_FLUSH)
                in_handler_q <= 1'b0;
        end
    end

`ifdef INTR_VECTORED_EN
    logic       irq_taken_q;
    logic [2:0] irq_line_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_taken_q <= 1'b0;
            irq_line_q  <= 3'd0;
        end else if (take_exc | take_irq) begin
            irq_taken_q <= take_irq;
            irq_line_q  <= irq_line;
        end
    end

    // Line i enters at base + 0x20*(i+1); exceptions use the base.
    assign entry_pc = irq_taken_q
                    ? ENTRY_BASE + {24'd0, irq_line_q + 3'd1, 5'd0}
                    : ENTRY_BASE;
`else
    assign entry_pc = ENTRY_BASE;
`endif

    assign bus.stall       = ~idle;
    assign bus.flush       = (state_q == FLUSH) | (state_q == ERET_FLUSH);
    assign bus.cp0_we      = (state_q == SAVE);
    assign bus.pc_redirect = (state_q == REDIR) | (state_q == ERET_REDIR);
    assign bus.redirect_pc = (state_q == REDIR)      ? entry_pc   :
                             (state_q == ERET_REDIR) ? bus.epc_in :
                             32'd0;
    assign bus.cause_code  = cause_q;
    assign bus.epc_out     = epc_q;
    assign bus.in_handler  = in_handler_q;
    assign bus.pending     = pend_q;
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (system clock, rising edge); reset input 1 (reset reset, synchronous, active-high).
REQ-002 SHALL have exc_valid input 1 (WB-stage exception flags qualified); ovf, divz, ri, brk, sys, eret inputs 1 each (exception sources).
REQ-003 SHALL have ext_irq input 6 (external interrupt lines); irq_mask input 6 (Status.IM); global_ie input 1 (Status.IE); exc_pc input 32 (faulting PC); epc_in input 32 (current EPC).
REQ-004 SHALL have stall output 1, flush output 1, cp0_we output 1 (CP0 save pulse), cause_code output 5, epc_out output 32, pc_redirect output 1, redirect_pc output 32, in_handler output 1, pending output 6.

Function
REQ-005 SHALL implement states IDLE, FLUSH, SAVE, REDIR, ERET_FLUSH, ERET_REDIR.
REQ-006 SHALL latch a pending bit on each rising edge of ext_irq[i] (edge versus the previous-cycle sample); pending[i] SHALL remain set until serviced.
REQ-007 An interrupt SHALL be eligible when (pending & irq_mask) != 0, global_ie=1 and in_handler=0; the lowest-index eligible bit wins.
REQ-008 In IDLE with exc_valid=1, priority SHALL be sys(01000) > divz(00111) > brk(01001) > ri(01010) > ovf(01100); with no exception flag, an eligible interrupt SHALL be selected with code 00000.
REQ-009 Synchronous exceptions SHALL be accepted regardless of global_ie and in_handler.
REQ-010 On acceptance in cycle N, the block SHALL register cause_code and epc_out=exc_pc and enter FLUSH at N+1.
REQ-011 On acceptance of an interrupt, the block SHALL clear the serviced pending bit at N+1.
REQ-012 FLUSH SHALL assert flush=1 for exactly one cycle.
REQ-013 SAVE SHALL assert cp0_we=1 for exactly one cycle, with cause_code and epc_out stable.
REQ-014 REDIR SHALL assert pc_redirect=1 for exactly one cycle with redirect_pc=entry address, set in_handler=1, and return to IDLE.
REQ-015 Total exception-entry latency SHALL be 3 cycles (acceptance to pc_redirect).
REQ-016 Entry address SHALL be 32'h0000F500, except as specified under Configuration.
REQ-017 In IDLE with exc_valid=1 and eret=1 and no other flag set, the block SHALL go to ERET_FLUSH (flush=1 for one cycle), then ERET_REDIR (pc_redirect=1, redirect_pc=epc_in, in_handler cleared), then IDLE.
REQ-018 eret combined with any other exception flag SHALL be ignored in favour of the exception.
REQ-019 stall SHALL be 1 in every state except IDLE.
REQ-020 exc_valid and flags arriving outside IDLE SHALL be ignored; edges SHALL still set pending bits.
REQ-021 A rising edge on the same bit in the same cycle as that bit is cleared SHALL leave the bit set (set wins).
REQ-022 An exception and an eligible interrupt in the same IDLE cycle SHALL service the exception; the interrupt SHALL remain pending.
REQ-023 cp0_we, flush and pc_redirect SHALL be mutually exclusive in every cycle.

Reset
REQ-024 reset SHALL force state IDLE, clear pending, the edge-sample register and in_handler, and drive all outputs to 0 on the next clock edge.
REQ-025 reset asserted mid-sequence SHALL abort the sequence with no further cp0_we or pc_redirect pulse.

Configuration
REQ-026 Macro INTR_VECTORED_EN:
- Defined: the interrupt entry address SHALL be 32'h0000F500 + 32'h20*(i+1) for serviced line i; exceptions SHALL keep 32'h0000F500.
- Undefined: all entries SHALL use 32'h0000F500.

Verification
REQ-027 Reset, then exc_valid=1, ovf=1, exc_pc=0x100 -> flush@N+1, cp0_we@N+2 with cause_code=01100 and epc_out=0x100, pc_redirect@N+3 with redirect_pc=0x0000F500, in_handler=1.
REQ-028 exc_valid=1 with sys=1 and ovf=1 together -> cause_code=01000.
REQ-029 ext_irq rises on bits 1 and 3, irq_mask=6'h3F, global_ie=1 -> bit 1 serviced with code 00000; pending=6'b001000 afterwards; bit 3 blocked until eret clears in_handler, then serviced.
REQ-030 ext_irq[2] rises with irq_mask[2]=0 -> pending[2]=1, no entry; set irq_mask[2]=1 -> entry begins next IDLE cycle.
REQ-031 eret with epc_in=0x200 while in_handler=1 -> flush 1 cycle, then pc_redirect with redirect_pc=0x200, in_handler=0.
REQ-032 reset asserted in SAVE -> no pc_redirect, state IDLE, all outputs 0; with INTR_VECTORED_EN defined, servicing line 0 -> redirect_pc=0x0000F520.
